// File: rtl/equilibrium_pkg.sv
// Shared types and constants for the stepper position controller.
package equilibrium_pkg;

  localparam int unsigned POS_W   = 16;
  localparam int unsigned TIMER_W = 16;

  localparam logic DIR_POS = 1'b1;
  localparam logic DIR_NEG = 1'b0;

  typedef enum logic [2:0] {
    StIdle,
    StHoming,
    StBackoff,
    StReady,
    StDirSetup,
    StStepHi,
    StStepLo,
    StFault
  } state_e;

  // What the end of a pulse means: still searching, backing off, or normal motion.
  typedef enum logic [1:0] {
    ModeHome,
    ModeBackoff,
    ModeRun
  } mode_e;

  function automatic logic signed [POS_W-1:0] clamp_pos(input logic signed [POS_W-1:0] v,
                                                         input int lo, input int hi);
    if (int'(v) < lo) return POS_W'(lo);
    if (int'(v) > hi) return POS_W'(hi);
    return v;
  endfunction

endpackage

// File: rtl/stepper_pos_ctrl_if.sv
// Command/status bundle between the position-command logic and the stepper controller.
interface stepper_pos_ctrl_if;
  import equilibrium_pkg::*;

  logic                    calib_start;
  logic                    sensorFimCurso;
  logic signed [POS_W-1:0] target_pos;
  logic                    target_valid;
  logic                    trava_servo;
  logic                    step;
  logic                    dir;
  logic signed [POS_W-1:0] current_pos;
  logic                    homed;
  logic                    busy;
  logic                    at_target;
  logic                    fault;

  modport master (
    output calib_start, sensorFimCurso, target_pos, target_valid, trava_servo,
    input  step, dir, current_pos, homed, busy, at_target, fault
  );

  modport slave (
    input  calib_start, sensorFimCurso, target_pos, target_valid, trava_servo,
    output step, dir, current_pos, homed, busy, at_target, fault
  );

endinterface

// File: rtl/step_pulse_timer.sv
// Down-counter timing the dir-setup, step-high and step-low phases; done while at zero.
module step_pulse_timer
  import equilibrium_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               done
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  // Loading N gives a phase lasting exactly N cycles (done on the last one).
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val - 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/stepper_pos_ctrl.sv
// Stepper driver: homes against the limit switch, then steps current_pos to clamped targets.
module stepper_pos_ctrl
  import equilibrium_pkg::*;
#(
  parameter int unsigned STEP_HIGH_CYC  = 500,
  parameter int unsigned STEP_LOW_CYC   = 500,
  parameter int unsigned DIR_SETUP_CYC  = 50,
  parameter int          POS_MIN        = -800,
  parameter int          POS_MAX        = 800,
  parameter int unsigned BACKOFF_STEPS  = 20,
  parameter int unsigned HOME_MAX_STEPS = 4000
) (
  input logic               clock,
  input logic               reset,
  stepper_pos_ctrl_if.slave bus
);

  localparam logic [TIMER_W-1:0] HiCyc      = TIMER_W'(STEP_HIGH_CYC);
  localparam logic [TIMER_W-1:0] LoCyc      = TIMER_W'(STEP_LOW_CYC);
  localparam logic [TIMER_W-1:0] SetupCyc   = TIMER_W'(DIR_SETUP_CYC);
  localparam logic [15:0]        HomeMax    = 16'(HOME_MAX_STEPS);
  localparam logic [15:0]        BackoffCnt = 16'(BACKOFF_STEPS);

  state_e                  state_q, state_d;
  mode_e                   mode_q, mode_d;
  logic                    dir_q, dir_d;
  logic signed [POS_W-1:0] pos_q, target_q;
  logic                    homed_q, fault_q;
  logic [15:0]             pulse_cnt_q;
  logic                    sw_meta_q, sw_sync_q;

  logic                    timer_load, timer_done;
  logic [TIMER_W-1:0]      timer_val;
  logic                    move_req, want_dir, pulse_start, fault_entry;
  logic                    pos_zero, rezero, home_done, cnt_clr;
  state_e                  launch_st;
  logic                    busy;

  function automatic state_e launch(input logic req, input logic want, input logic cur);
    if (!req) return StReady;
    if (want == cur) return StStepHi;
    return StDirSetup;
  endfunction

  assign move_req  = (target_q != pos_q) && !bus.trava_servo;
  assign want_dir  = (target_q > pos_q) ? DIR_POS : DIR_NEG;
  assign launch_st = launch(move_req, want_dir, dir_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      mode_q  <= ModeHome;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    dir_d     = dir_q;
    pos_zero  = 1'b0;
    rezero    = 1'b0;
    home_done = 1'b0;
    cnt_clr   = 1'b0;
    if (bus.calib_start) begin
      state_d = StHoming;
      mode_d  = ModeHome;
      dir_d   = DIR_NEG;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        StIdle, StFault: ;
        StHoming: begin
          if (timer_done) begin
            if (sw_sync_q) begin
              state_d  = StBackoff;
              mode_d   = ModeBackoff;
              dir_d    = DIR_POS;
              pos_zero = 1'b1;
              cnt_clr  = 1'b1;
            end else begin
              state_d = StStepHi;
            end
          end
        end
        StBackoff: if (timer_done) state_d = StStepHi;
        StReady: begin
          state_d = launch_st;
          if (launch_st == StDirSetup) dir_d = want_dir;
        end
        StDirSetup: begin
          if (timer_done) begin
            state_d = launch_st;
            if (launch_st == StDirSetup) dir_d = want_dir;
          end
        end
        StStepHi: if (timer_done) state_d = StStepLo;
        StStepLo: begin
          if (timer_done) begin
            unique case (mode_q)
              ModeHome: begin
                if (sw_sync_q) begin
                  state_d  = StBackoff;
                  mode_d   = ModeBackoff;
                  dir_d    = DIR_POS;
                  pos_zero = 1'b1;
                  cnt_clr  = 1'b1;
                end else if (pulse_cnt_q == HomeMax) begin
                  state_d = StFault;
                end else begin
                  state_d = StStepHi;
                end
              end
              ModeBackoff: begin
                if (pulse_cnt_q == BackoffCnt) begin
                  state_d   = StReady;
                  mode_d    = ModeRun;
                  home_done = 1'b1;
                end else begin
                  state_d = StStepHi;
                end
              end
              default: begin
                // Hitting the switch while heading toward it re-references the axis.
                if (sw_sync_q && dir_q == DIR_NEG) begin
                  state_d  = StReady;
                  pos_zero = 1'b1;
                  rezero   = 1'b1;
                end else begin
                  state_d = launch_st;
                  if (launch_st == StDirSetup) dir_d = want_dir;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  assign pulse_start = (state_d == StStepHi) && (state_q != StStepHi);
  assign fault_entry = (state_d == StFault) && (state_q != StFault);
  assign timer_load  = (state_d != state_q) || (dir_d != dir_q) || bus.calib_start;
  assign timer_val   = (state_d == StStepHi) ? HiCyc :
                       (state_d == StStepLo) ? LoCyc : SetupCyc;

  step_pulse_timer u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sw_meta_q <= 1'b0;
      sw_sync_q <= 1'b0;
    end else begin
      sw_meta_q <= bus.sensorFimCurso;
      sw_sync_q <= sw_meta_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dir_q       <= DIR_NEG;
      pos_q       <= '0;
      target_q    <= '0;
      homed_q     <= 1'b0;
      fault_q     <= 1'b0;
      pulse_cnt_q <= '0;
    end else begin
      dir_q <= dir_d;
      if (pos_zero) begin
        pos_q <= '0;
      end else if (pulse_start) begin
        pos_q <= (dir_q == DIR_POS) ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
      end
      if (rezero) begin
        target_q <= '0;
      end else if (home_done) begin
        target_q <= pos_q;
      end else if (bus.target_valid && homed_q && !bus.calib_start) begin
        target_q <= clamp_pos(bus.target_pos, POS_MIN, POS_MAX);
      end
      if (bus.calib_start || fault_entry) begin
        homed_q <= 1'b0;
      end else if (home_done) begin
        homed_q <= 1'b1;
      end
      if (bus.calib_start) begin
        fault_q <= 1'b0;
      end else if (fault_entry) begin
        fault_q <= 1'b1;
      end
      if (cnt_clr) begin
        pulse_cnt_q <= '0;
      end else if (pulse_start) begin
        pulse_cnt_q <= pulse_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    busy            = !(state_q inside {StIdle, StReady, StFault});
    bus.step        = (state_q == StStepHi);
    bus.busy        = busy;
    bus.dir         = dir_q;
    bus.current_pos = pos_q;
    bus.homed       = homed_q;
    bus.fault       = fault_q;
    bus.at_target   = homed_q && !busy && (pos_q == target_q);
  end

endmodule

// File: tb/tb_stepper_pos_ctrl.sv
// Scoreboard bench: stimulus queues the pulses it expects, a monitor checks every step edge.
module tb_stepper_pos_ctrl;
  import equilibrium_pkg::*;

  localparam int STEP_HIGH_CYC  = 2;
  localparam int STEP_LOW_CYC   = 2;
  localparam int DIR_SETUP_CYC  = 1;
  localparam int POS_MIN        = -800;
  localparam int POS_MAX        = 800;
  localparam int BACKOFF_STEPS  = 3;
  localparam int HOME_MAX_STEPS = 10;

  typedef struct {
    bit dir;
    int pos;
  } pulse_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  stepper_pos_ctrl_if bus ();

  stepper_pos_ctrl #(
    .STEP_HIGH_CYC  (STEP_HIGH_CYC),
    .STEP_LOW_CYC   (STEP_LOW_CYC),
    .DIR_SETUP_CYC  (DIR_SETUP_CYC),
    .POS_MIN        (POS_MIN),
    .POS_MAX        (POS_MAX),
    .BACKOFF_STEPS  (BACKOFF_STEPS),
    .HOME_MAX_STEPS (HOME_MAX_STEPS)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial forever #5 clock = ~clock;

  int     vectors     = 0;
  int     miscompares = 0;
  int     pulses_seen = 0;
  int     model_pos   = 0;
  bit     mon_en      = 1'b0;
  pulse_t exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clamp_i(input int v);
    return (v < POS_MIN) ? POS_MIN : (v > POS_MAX) ? POS_MAX : v;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // One expected pulse per unit of travel, each carrying the position after that pulse.
  task automatic push_path(input int from, input int to);
    pulse_t e;
    if (to > from) begin
      for (int p = from + 1; p <= to; p++) begin e.dir = 1'b1; e.pos = p; exp_q.push_back(e); end
    end else begin
      for (int p = from - 1; p >= to; p--) begin e.dir = 1'b0; e.pos = p; exp_q.push_back(e); end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic issue_target(input int v);
    bus.target_pos   = 16'(v);
    bus.target_valid = 1'b1;
    @(negedge clock);
    bus.target_valid = 1'b0;
  endtask

  task automatic calib();
    bus.calib_start = 1'b1;
    @(negedge clock);
    bus.calib_start = 1'b0;
  endtask

  task automatic wait_pulses(input int n);
    int k = 0;
    while (pulses_seen < n && k < 200) begin @(negedge clock); k++; end
    if (pulses_seen < n) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_pulses: saw %0d pulses, required %0d", pulses_seen, n);
    end
  endtask

  task automatic wait_settle(input int budget);
    int k = 0;
    tick(2);
    while (bus.busy && k < budget) begin @(negedge clock); k++; end
    if (bus.busy) begin
      vectors++;
      miscompares++;
      $display("FAIL settle_timeout: busy=1 after %0d cycles, required 0", budget);
    end
  endtask

  task automatic finish_move(input int tc, input int npulses);
    wait_settle((npulses + 4) * 6 + 40);
    chk("move_pos", bus.current_pos, tc);
    chk("move_at_target", bus.at_target, 1);
    chk("move_queue_drained", exp_q.size(), 0);
    model_pos = tc;
  endtask

  task automatic move(input int t);
    int tc;
    tc = clamp_i(t);
    push_path(model_pos, tc);
    issue_target(t);
    finish_move(tc, iabs(tc - model_pos));
  endtask

  // Monitor: pulse shape, dir setup/hold, and each rising edge against the scoreboard.
  initial begin
    bit     prev_step, prev_dir, have_fall;
    int     hi_len, lo_len, dir_len;
    pulse_t e;
    prev_step = 1'b0; prev_dir = 1'b0; have_fall = 1'b0;
    hi_len = 0; lo_len = 0; dir_len = 0;
    forever begin
      @(negedge clock);
      if (!mon_en) begin
        prev_step = bus.step; prev_dir = bus.dir;
        hi_len = 0; lo_len = 0; dir_len = 0; have_fall = 1'b0;
      end else begin
        dir_len = (bus.dir == prev_dir) ? dir_len + 1 : 1;
        if (bus.step && prev_step) chk("dir_held_in_pulse", bus.dir, prev_dir);
        if (bus.step && !prev_step) begin
          pulses_seen++;
          chk("dir_setup", (dir_len > DIR_SETUP_CYC) ? 1 : 0, 1);
          if (have_fall) chk("low_width_ok", (lo_len >= STEP_LOW_CYC) ? 1 : 0, 1);
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_pulse: pulse to pos %0d, none expected", bus.current_pos);
          end else begin
            e = exp_q.pop_front();
            chk("pulse_dir", bus.dir, e.dir);
            chk("pulse_pos", bus.current_pos, e.pos);
          end
          hi_len = 1;
        end else if (bus.step) begin
          hi_len++;
        end
        if (!bus.step && prev_step) begin
          chk("high_width", hi_len, STEP_HIGH_CYC);
          lo_len    = 1;
          have_fall = 1'b1;
        end else if (!bus.step) begin
          lo_len++;
        end
        prev_step = bus.step;
        prev_dir  = bus.dir;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, p, t;
    bus.calib_start = 1'b0; bus.sensorFimCurso = 1'b0; bus.target_pos = '0;
    bus.target_valid = 1'b0; bus.trava_servo = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(2);
    chk("rst_step", bus.step, 0);
    chk("rst_dir", bus.dir, 0);
    chk("rst_pos", bus.current_pos, 0);
    chk("rst_homed", bus.homed, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_at_target", bus.at_target, 0);
    chk("rst_fault", bus.fault, 0);
    mon_en = 1'b1;

    // Target before homing is ignored.
    issue_target(5);
    tick(30);
    chk("prehome_pulses", pulses_seen, 0);
    chk("prehome_busy", bus.busy, 0);

    // Asynchronous reset in the middle of a homing pulse.
    mon_en = 1'b0;
    calib();
    begin
      int k = 0;
      while (!bus.step && k < 50) begin @(negedge clock); k++; end
    end
    chk("midpulse_step_before_rst", bus.step, 1);
    reset = 1'b0;
    #1;
    chk("midpulse_rst_step", bus.step, 0);
    chk("midpulse_rst_pos", bus.current_pos, 0);
    chk("midpulse_rst_homed", bus.homed, 0);
    @(negedge clock);
    reset = 1'b1;
    tick(3);
    mon_en = 1'b1;
    tick(3);

    // Homing: switch after 4 pulses, then 3 backoff pulses.
    base = pulses_seen;
    push_path(0, -4);
    push_path(0, BACKOFF_STEPS);
    calib();
    wait_pulses(base + 4);
    bus.sensorFimCurso = 1'b1;
    wait_pulses(base + 5);
    bus.sensorFimCurso = 1'b0;
    wait_settle(200);
    chk("home_pos", bus.current_pos, BACKOFF_STEPS);
    chk("home_homed", bus.homed, 1);
    chk("home_at_target", bus.at_target, 1);
    chk("home_queue_drained", exp_q.size(), 0);
    model_pos = BACKOFF_STEPS;

    move(-2);

    // Clamped target, retargeted during the second pulse.
    base = pulses_seen;
    push_path(model_pos, clamp_i(900));
    issue_target(900);
    wait_pulses(base + 2);
    exp_q.delete();
    model_pos = model_pos + 2;
    push_path(model_pos, -4);
    issue_target(-4);
    finish_move(-4, iabs(-4 - model_pos));

    move(900);

    // Hold mid-pulse, then release.
    p = model_pos;
    base = pulses_seen;
    push_path(p, p - 6);
    issue_target(p - 6);
    wait_pulses(base + 2);
    bus.trava_servo = 1'b1;
    tick(30);
    chk("hold_pulses", pulses_seen, base + 2);
    chk("hold_pos", bus.current_pos, p - 2);
    chk("hold_busy", bus.busy, 0);
    bus.trava_servo = 1'b0;
    finish_move(p - 6, 4);

    // Switch while moving toward it re-references to zero.
    p = model_pos;
    base = pulses_seen;
    push_path(p, p - 6);
    issue_target(p - 6);
    wait_pulses(base + 2);
    exp_q.delete();
    bus.sensorFimCurso = 1'b1;
    wait_settle(60);
    bus.sensorFimCurso = 1'b0;
    chk("reref_pos", bus.current_pos, 0);
    chk("reref_at_target", bus.at_target, 1);
    chk("reref_homed", bus.homed, 1);
    chk("reref_queue_drained", exp_q.size(), 0);
    model_pos = 0;
    tick(4);

    for (int i = 0; i < 10; i++) begin
      t = int'($urandom_range(0, 80)) - 40;
      if (i == 7) t = (t < 0) ? t - 900 : t + 900;
      move(t);
    end

    // Homing timeout.
    base = pulses_seen;
    push_path(model_pos, model_pos - HOME_MAX_STEPS);
    calib();
    wait_settle(HOME_MAX_STEPS * 6 + 40);
    chk("fault_set", bus.fault, 1);
    chk("fault_homed", bus.homed, 0);
    chk("fault_step", bus.step, 0);
    chk("fault_pulses", pulses_seen - base, HOME_MAX_STEPS);
    tick(20);
    chk("fault_no_more_pulses", pulses_seen - base, HOME_MAX_STEPS);
    mon_en = 1'b0;
    calib();
    chk("fault_cleared", bus.fault, 0);
    chk("fault_rehome_busy", bus.busy, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
